// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity modes
// and the default bit period for a 100 MHz clock at 9600 baud.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible whenever valid is high.
// A write into a full FIFO succeeds only when a read frees a slot on the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             pop;
  logic             push;

  assign full     = (count_reg == CW'(DEPTH));
  assign pop      = rd_en && (count_reg != '0);
  assign push     = wr_en && (!full || pop);
  assign overflow = wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign valid   = (count_reg != '0);
  assign count   = count_reg;
  // Masked when empty so the outputs read as zero out of reset.
  assign rd_data = valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit glitch rejection, optional parity and a receive FIFO
// that stores each frame with its framing and parity error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          UART_RXD,
  output logic [DATA_BITS-1:0]          DATA,
  output logic                          VALID,
  input  logic                          READ,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  output logic                          OVERRUN,
  input  logic                          CLR_ERR,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT
);

  localparam int            WIDTH    = DATA_BITS + 2;
  localparam logic [15:0]   HALF_CYC = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0]   LAST_CYC = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rx_meta_reg;
  logic                 rxs;
  rx_state_t            state_reg,  state_next;
  logic [15:0]          cyc_reg,    cyc_next;
  logic [3:0]           bit_reg,    bit_next;
  logic [DATA_BITS-1:0] shift_reg,  shift_next;
  logic                 perr_reg,   perr_next;
  logic                 overrun_reg;
  logic                 push;
  logic                 overflow;
  logic [WIDTH-1:0]     push_data;
  logic [WIDTH-1:0]     head;

  // Synchronizer idles high so a reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_reg <= 1'b1;
      rxs         <= 1'b1;
    end else begin
      rx_meta_reg <= UART_RXD;
      rxs         <= rx_meta_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      cyc_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      perr_reg  <= perr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    perr_next  = perr_reg;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rxs) begin
          state_next = ST_START;
          cyc_next   = '0;
          bit_next   = '0;
          perr_next  = 1'b0;
        end
      end
      ST_START: begin
        // Line back high at mid start bit means it was only a glitch.
        if (cyc_reg == HALF_CYC) begin
          cyc_next   = '0;
          state_next = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      ST_DATA: begin
        if (cyc_reg == LAST_CYC) begin
          cyc_next   = '0;
          shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
          bit_next   = bit_reg + 4'd1;
          if (bit_reg == LAST_BIT) begin
            state_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      ST_PARITY: begin
        if (cyc_reg == LAST_CYC) begin
          cyc_next   = '0;
          perr_next  = ((^shift_reg) ^ rxs) != (PARITY == PAR_ODD);
          state_next = ST_STOP;
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      ST_STOP: begin
        // Push at mid stop bit; the rest of the stop bit is spent in IDLE.
        if (cyc_reg == LAST_CYC) begin
          cyc_next   = '0;
          push       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cyc_next = cyc_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign push_data = {shift_reg, ~rxs, perr_reg};

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .srst     (RST),
    .wr_en    (push),
    .wr_data  (push_data),
    .rd_en    (READ),
    .rd_data  (head),
    .valid    (VALID),
    .count    (COUNT),
    .overflow (overflow)
  );

  // A new overrun takes priority over a clear on the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overrun_reg <= 1'b0;
    end else if (overflow) begin
      overrun_reg <= 1'b1;
    end else if (CLR_ERR) begin
      overrun_reg <= 1'b0;
    end
  end

  assign OVERRUN    = overrun_reg;
  assign DATA       = head[WIDTH-1:2];
  assign FRAME_ERR  = head[1];
  assign PARITY_ERR = head[0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (8N1 and 8E1, both 4-deep) driven by
// directed frame tables, hand-timed FIFO corner cases and random frames vs a queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_n = 1'b1, rxd_e = 1'b1;
  logic       read_n = 1'b0, read_e = 1'b0;
  logic       clr_n = 1'b0, clr_e = 1'b0;
  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e, ferr_n, ferr_e, perr_n, perr_e, ovr_n, ovr_e;
  logic [2:0] count_n, count_e;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } ent_t;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  ent_t qn[$];
  logic ov_model = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .FIFO_DEPTH(DEPTH)) dut_n (
    .CLK(clk), .RST(rst), .UART_RXD(rxd_n), .DATA(data_n), .VALID(valid_n), .READ(read_n),
    .FRAME_ERR(ferr_n), .PARITY_ERR(perr_n), .OVERRUN(ovr_n), .CLR_ERR(clr_n), .COUNT(count_n));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .FIFO_DEPTH(DEPTH)) dut_e (
    .CLK(clk), .RST(rst), .UART_RXD(rxd_e), .DATA(data_e), .VALID(valid_e), .READ(read_e),
    .FRAME_ERR(ferr_e), .PARITY_ERR(perr_e), .OVERRUN(ovr_e), .CLR_ERR(clr_e), .COUNT(count_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rxd_n = b;
    else          rxd_e = b;
  endtask

  // Start bit, 8 data bits LSB first, parity (instance 1 only), stop bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] bits;
    int nb;
    if (sel == 0) begin
      bits = {1'b1, stop, d, 1'b0};
      nb   = 10;
    end else begin
      bits = {stop, p, d, 1'b0};
      nb   = 11;
    end
    for (int i = 0; i < nb; i++) begin
      drive(sel, bits[i]);
      repeat (CPB) tick();
    end
    drive(sel, 1'b1);
    $display("frame dut%0d data=0x%02h par=%0b stop=%0b", sel, d, p, stop);
  endtask

  task automatic pop(input int sel);
    if (sel == 0) read_n = 1'b1;
    else          read_e = 1'b1;
    tick();
    read_n = 1'b0;
    read_e = 1'b0;
  endtask

  task automatic model_push(input ent_t e);
    if (qn.size() < DEPTH) qn.push_back(e);
    else                   ov_model = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    ent_t e;
    logic [7:0] rd;
    logic p;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[2] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[4] = '{0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

    // Reset state
    idle(3);
    chk("rst_valid_n", valid_n, 0);
    chk("rst_count_n", count_n, 0);
    chk("rst_data_n", data_n, 0);
    chk("rst_ferr_n", ferr_n, 0);
    chk("rst_ovr_n", ovr_n, 0);
    chk("rst_valid_e", valid_e, 0);
    chk("rst_perr_e", perr_e, 0);
    rst = 1'b0;
    idle(10);

    // Directed frame table
    foreach (vecs[i]) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop);
      idle(20);
      if (vecs[i].sel == 0) begin
        chk($sformatf("vec%0d_valid", i), valid_n, 1);
        chk($sformatf("vec%0d_data", i), data_n, vecs[i].exp_data);
        chk($sformatf("vec%0d_ferr", i), ferr_n, vecs[i].exp_ferr);
        chk($sformatf("vec%0d_perr", i), perr_n, vecs[i].exp_perr);
        chk($sformatf("vec%0d_count", i), count_n, 1);
      end else begin
        chk($sformatf("vec%0d_valid", i), valid_e, 1);
        chk($sformatf("vec%0d_data", i), data_e, vecs[i].exp_data);
        chk($sformatf("vec%0d_ferr", i), ferr_e, vecs[i].exp_ferr);
        chk($sformatf("vec%0d_perr", i), perr_e, vecs[i].exp_perr);
        chk($sformatf("vec%0d_count", i), count_e, 1);
      end
      pop(vecs[i].sel);
      chk($sformatf("vec%0d_empty", i), vecs[i].sel == 0 ? count_n : count_e, 0);
    end

    // Start-bit glitch is rejected, then a real frame is received
    rxd_n = 1'b0;
    idle(5);
    rxd_n = 1'b1;
    idle(30);
    chk("glitch_count", count_n, 0);
    chk("glitch_valid", valid_n, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    idle(20);
    chk("post_glitch_data", data_n, 8'h3C);
    chk("post_glitch_count", count_n, 1);
    pop(0);

    // Overflow, with CLR_ERR landing on the dropped push (set wins)
    for (int i = 1; i <= 4; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b1);
      idle(20);
    end
    chk("full_count", count_n, 4);
    chk("full_ovr_before", ovr_n, 0);
    fork
      send_frame(0, 8'h05, 1'b0, 1'b1);
      begin
        repeat (155) tick();
        clr_n = 1'b1;
        tick();
        clr_n = 1'b0;
      end
    join
    idle(20);
    chk("ovr_set_wins", ovr_n, 1);
    chk("ovr_count", count_n, 4);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_pop%0d", i), data_n, 8'(i));
      pop(0);
    end
    chk("ovr_drained", valid_n, 0);
    pop(0);
    chk("read_empty_ignored", count_n, 0);
    clr_n = 1'b1;
    tick();
    clr_n = 1'b0;
    chk("ovr_cleared", ovr_n, 0);

    // Full FIFO with a pop on the push cycle: the push succeeds
    for (int i = 0; i < 4; i++) begin
      send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b1);
      idle(20);
    end
    fork
      send_frame(0, 8'h77, 1'b0, 1'b1);
      begin
        repeat (155) tick();
        read_n = 1'b1;
        tick();
        read_n = 1'b0;
      end
    join
    idle(20);
    chk("pushpop_count", count_n, 4);
    chk("pushpop_ovr", ovr_n, 0);
    for (int i = 0; i < 4; i++) begin
      rd = (i == 3) ? 8'h77 : 8'h11 + 8'(i);
      chk($sformatf("pushpop_pop%0d", i), data_n, rd);
      pop(0);
    end

    // Reset mid-frame abandons the frame and empties the FIFO
    send_frame(0, 8'h42, 1'b0, 1'b1);
    idle(20);
    chk("prerst_count", count_n, 1);
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b1);
      begin
        repeat (CPB * 5 + 8) tick();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
    join
    idle(20);
    chk("midrst_count", count_n, 0);
    chk("midrst_valid", valid_n, 0);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    idle(20);
    chk("postrst_data", data_n, 8'h81);
    chk("postrst_ferr", ferr_n, 0);
    pop(0);
    qn.delete();
    ov_model = 1'b0;

    // Random frames on the 8N1 instance against the queue model
    for (int it = 0; it < 40; it++) begin
      e.data = 8'($urandom);
      e.ferr = ($urandom_range(0, 7) == 0);
      e.perr = 1'b0;
      send_frame(0, e.data, 1'b0, ~e.ferr);
      model_push(e);
      idle(20 + $urandom_range(0, 20));
      chk($sformatf("rnd%0d_count", it), count_n, qn.size());
      chk($sformatf("rnd%0d_ovr", it), ovr_n, ov_model);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        if (qn.size() > 0) begin
          chk($sformatf("rnd%0d_data", it), data_n, qn[0].data);
          chk($sformatf("rnd%0d_ferr", it), ferr_n, qn[0].ferr);
          void'(qn.pop_front());
        end else begin
          chk($sformatf("rnd%0d_valid", it), valid_n, 0);
        end
        pop(0);
        chk($sformatf("rnd%0d_popcount", it), count_n, qn.size());
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_n = 1'b1;
        tick();
        clr_n = 1'b0;
        ov_model = 1'b0;
      end
    end

    // Random frames on the 8E1 instance: parity error iff the 9 bits hold an odd count of ones
    for (int it = 0; it < 10; it++) begin
      rd = 8'($urandom);
      p  = 1'($urandom);
      send_frame(1, rd, p, 1'b1);
      idle(20);
      chk($sformatf("rpar%0d_data", it), data_e, rd);
      chk($sformatf("rpar%0d_perr", it), perr_e, ($countones({rd, p}) % 2) != 0);
      pop(1);
      chk($sformatf("rpar%0d_empty", it), count_e, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
